// File: rtl/carry_chain_adder_pipe.sv
// Pipelined add/sub built from cascaded 4-bit carry slices, one STAGE_BITS
// slice per stage, with triangular input skew and output de-skew.
module carry_chain_adder_pipe #(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);
  localparam int NSTAGES = WIDTH / STAGE_BITS;
  localparam int SB      = STAGE_BITS;

  logic               adv;
  logic [WIDTH-1:0]   b_eff;
  logic [NSTAGES-1:0] vld_q;
  logic [NSTAGES-1:0] cy;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NSTAGES-1];
  assign out_co    = cy[NSTAGES-1];
  assign b_eff     = in_sub ? ~in_b : in_b;

  // One 4-bit carry slice: O = S ^ C, CO = S ? CI : DI.
  function automatic logic [4:0] carry4(
    input logic [3:0] s,
    input logic [3:0] di,
    input logic       ci
  );
    logic [4:0] c;
    logic [3:0] o;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      o[i]   = s[i] ^ c[i];
      c[i+1] = s[i] ? c[i] : di[i];
    end
    return {c[4], o};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < NSTAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    logic [SB-1:0] a_op;
    logic [SB-1:0] b_op;
    logic [SB-1:0] s_w;
    logic          ci_op;
    logic          co_w;
    logic          cc;
    logic [4:0]    r4;
    logic          c_q;
    logic [SB-1:0] d_q [NSTAGES-k];

    if (k == 0) begin : g_in
      assign a_op  = in_a[SB-1:0];
      assign b_op  = b_eff[SB-1:0];
      assign ci_op = in_ci;
    end else begin : g_skew
      logic [SB-1:0] a_q [k];
      logic [SB-1:0] b_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
          end
        end else if (adv) begin
          a_q[0] <= in_a[k*SB +: SB];
          b_q[0] <= b_eff[k*SB +: SB];
          for (int j = 1; j < k; j++) begin
            a_q[j] <= a_q[j-1];
            b_q[j] <= b_q[j-1];
          end
        end
      end

      assign a_op  = a_q[k-1];
      assign b_op  = b_q[k-1];
      assign ci_op = cy[k-1];
    end

    always_comb begin
      cc  = ci_op;
      r4  = '0;
      s_w = '0;
      for (int n = 0; n < SB/4; n++) begin
        r4 = carry4(a_op[n*4 +: 4] ^ b_op[n*4 +: 4],
                    a_op[n*4 +: 4], cc);
        s_w[n*4 +: 4] = r4[3:0];
        cc = r4[4];
      end
      co_w = cc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= 1'b0;
        for (int j = 0; j < NSTAGES-k; j++) begin
          d_q[j] <= '0;
        end
      end else if (adv) begin
        c_q    <= co_w;
        d_q[0] <= s_w;
        for (int j = 1; j < NSTAGES-k; j++) begin
          d_q[j] <= d_q[j-1];
        end
      end
    end

    assign cy[k]               = c_q;
    assign out_sum[k*SB +: SB] = d_q[NSTAGES-k-1];

    if (k == NSTAGES-1) begin : g_ovf
      logic ov_q;
      // carry into the MSB is S ^ O at that bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= co_w ^ (a_op[SB-1] ^ b_op[SB-1] ^ s_w[SB-1]);
        end
      end
      assign out_ovf = ov_q;
    end
  end

endmodule

// File: tb/tb_carry_chain_adder_pipe.sv
// Bench for carry_chain_adder_pipe at NSTAGES 4, 8 and 1 against an
// arithmetic reference model with per-instance scoreboards.
module tb_carry_chain_adder_pipe;
  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        ci, sub;
  logic [2:0]  iv, irdy, oval, ordy, oco, oov;
  logic [31:0] osum [3];

  int ns [3] = '{4, 8, 1};
  exp_t mq [3][$];
  int nacc [3];
  logic acc_last [3];
  logic stl [3];
  logic [33:0] psnap [3];
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  bit strict = 1'b0;

  always #5 clk = ~clk;

  carry_chain_adder_pipe #(.WIDTH(32), .STAGE_BITS(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(a), .in_b(b), .in_ci(ci), .in_sub(sub),
    .out_valid(oval[0]), .out_ready(ordy[0]), .out_sum(osum[0]),
    .out_co(oco[0]), .out_ovf(oov[0]));

  carry_chain_adder_pipe #(.WIDTH(32), .STAGE_BITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(a), .in_b(b), .in_ci(ci), .in_sub(sub),
    .out_valid(oval[1]), .out_ready(ordy[1]), .out_sum(osum[1]),
    .out_co(oco[1]), .out_ovf(oov[1]));

  carry_chain_adder_pipe #(.WIDTH(32), .STAGE_BITS(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(a), .in_b(b), .in_ci(ci), .in_sub(sub),
    .out_valid(oval[2]), .out_ready(ordy[2]), .out_sum(osum[2]),
    .out_co(oco[2]), .out_ovf(oov[2]));

  function automatic exp_t model(
    input logic [31:0] xa, input logic [31:0] xb,
    input logic xci, input logic xsub);
    exp_t m;
    logic [31:0] bb;
    logic [32:0] r;
    bb = xsub ? ~xb : xb;
    r = {1'b0, xa} + {1'b0, bb} + {32'b0, xci};
    m.s = r[31:0];
    m.co = r[32];
    m.ov = (xa[31] == bb[31]) && (r[31] != xa[31]);
    m.cyc = 0;
    return m;
  endfunction

  function automatic logic [31:0] rnd();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) r = {32{r[0]}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Sample 1 time unit after the negedge, then step to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("in_ready[d%0d]", d), irdy[d],
          !(oval[d] && !ordy[d]));
      if (stl[d]) begin
        chk($sformatf("stall_valid[d%0d]", d), oval[d], 1'b1);
        chk($sformatf("stall_hold[d%0d]", d),
            {osum[d], oco[d], oov[d]}, psnap[d]);
      end
      acc_last[d] = iv[d] && irdy[d];
      if (acc_last[d]) begin
        e = model(a, b, ci, sub);
        e.cyc = cyc;
        mq[d].push_back(e);
        nacc[d]++;
      end
      if (oval[d] && ordy[d]) begin
        if (mq[d].size() == 0) begin
          chk($sformatf("spurious[d%0d]", d), oval[d], 1'b0);
        end else begin
          e = mq[d].pop_front();
          chk($sformatf("result[d%0d]", d),
              {osum[d], oco[d], oov[d]}, {e.s, e.co, e.ov});
          if (strict)
            chk($sformatf("latency[d%0d]", d), cyc - e.cyc, ns[d]);
        end
      end
      stl[d] = oval[d] && !ordy[d];
      psnap[d] = {osum[d], oco[d], oov[d]};
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] xa, input logic [31:0] xb,
                          input logic xci, input logic xsub,
                          input logic [31:0] es, input logic eco,
                          input logic eov, input string tag);
    a = xa; b = xb; ci = xci; sub = xsub;
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (3) tick();
    #1;
    chk({tag, "_valid"}, oval[0], 1'b1);
    chk({tag, "_sum"}, osum[0], es);
    chk({tag, "_co"}, oco[0], eco);
    chk({tag, "_ovf"}, oov[0], eov);
    tick();
  endtask

  task automatic stream(input int d, input int n, input int pv,
                        input int pr);
    int start;
    int guard;
    start = nacc[d];
    guard = 0;
    while (nacc[d] - start < n && guard < n * 20) begin
      if (!iv[d] || acc_last[d]) begin
        iv[d] = ($urandom_range(99) < pv);
        a = rnd();
        b = rnd();
        ci = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
      end
      ordy[d] = ($urandom_range(99) < pr);
      tick();
      guard++;
    end
    iv[d] = 1'b0;
    chk($sformatf("accepts[d%0d]", d), nacc[d] - start, n);
    ordy[d] = 1'b1;
    guard = 0;
    while (mq[d].size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk($sformatf("drain[d%0d]", d), mq[d].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv = '0;
    ordy = '1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    for (int d = 0; d < 3; d++) begin
      nacc[d] = 0;
      acc_last[d] = 1'b0;
      stl[d] = 1'b0;
      psnap[d] = '0;
    end
    @(negedge clk);
    #1;
    chk("rst_valid", oval[0], 1'b0);
    chk("rst_ready", irdy[0], 1'b1);
    chk("rst_sum", osum[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_valid", oval[0], 1'b0);
      chk("idle_sum", osum[0], 32'h0);
      chk("idle_ready", irdy[0], 1'b1);
      tick();
    end

    strict = 1'b1;
    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, "ripple");
    directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    directed(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1,
             32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");

    stream(0, 100, 100, 100);
    strict = 1'b0;
    stream(0, 200, 60, 50);

    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      a = rnd(); b = rnd();
      ci = 1'($urandom_range(1));
      sub = 1'($urandom_range(1));
      tick();
    end
    iv[0] = 1'b0;
    chk("inflight", mq[0].size(), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", oval[0], 1'b0);
    chk("mid_rst_sum", osum[0], 32'h0);
    chk("mid_rst_co", oco[0], 1'b0);
    chk("mid_rst_ovf", oov[0], 1'b0);
    chk("mid_rst_ready", irdy[0], 1'b1);
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      stl[d] = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("post_rst_valid", oval[0], 1'b0);
      tick();
    end

    strict = 1'b1;
    stream(1, 60, 100, 100);
    stream(1, 40, 70, 100);
    stream(2, 60, 100, 100);
    stream(2, 40, 70, 100);
    strict = 1'b0;
    stream(1, 60, 70, 50);
    stream(2, 60, 70, 50);

    for (int d = 0; d < 3; d++)
      chk($sformatf("final_empty[d%0d]", d), mq[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/carry_chain_adder_pipe.md
# carry_chain_adder_pipe

Parametrised, pipelined adder/subtractor built from cascaded 4-bit fast carry-chain slices. It breaks a WIDTH-bit carry-propagate add into pipeline stages of STAGE_BITS bits each, so wide adds close timing at full clock rate, and it exposes a valid/ready stream interface. It sits between operand producers and any wide arithmetic consumer (accumulators, address generators, counters), replacing hand-instantiated single 4-bit carry slices.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGE_BITS.
- STAGE_BITS, 8, bits resolved per pipeline stage; must be a multiple of 4 (one carry slice per 4 bits).
- NSTAGES, WIDTH/STAGE_BITS, derived (localparam): pipeline depth.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ci  in  1  carry-in to bit 0 (slice CYINIT).
- in_sub  in  1  0: A+B+ci; 1: A+~B+ci (ci=1 gives A−B).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_co  out  1  carry out of bit WIDTH−1.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Each STAGE_BITS slice: STAGE_BITS/4 cascaded 4-bit carry slices, S = a ^ b', DI = a, where b' = in_sub ? ~b : b.
- Stage k (0..NSTAGES−1) resolves bits [k·STAGE_BITS +: STAGE_BITS] from the registered carry of stage k−1; stage 0 takes in_ci.
- Input skew: the operand bits for slice k are delayed k cycles in triangular skew registers. Output de-skew: the sum for slice k is delayed NSTAGES−1−k cycles, so all bits of one result emerge together.
- A per-stage valid bit travels with the data. out_valid is the valid bit of the last stage.
- Global advance: adv = !out_valid || out_ready. When adv=1, all stages shift one step. When adv=0, all stages, skew registers and outputs hold.
- in_ready = adv. An input is accepted when in_valid && in_ready.
- Bubbles (invalid stages) are not compressed. They advance like data.
- Arithmetic is modulo 2^WIDTH. out_co is the unsigned carry (for subtract, 1 means no borrow).
- in_sub, in_ci and the operands are sampled only on acceptance. Each transaction carries its own mode.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, out_valid=0, out_sum=0, out_co=0, out_ovf=0. Skew/data registers are also cleared to 0.
- Reset asserted mid-operation drops all in-flight results. No output is produced for them.
- in_ready is 1 during and immediately after reset whenever out_valid=0.
- Latency: an input accepted at edge t produces out_valid=1 after edge t+NSTAGES−1, i.e. NSTAGES cycles with no stall. NSTAGES=1 means the result is registered once.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, out_sum/out_co/out_ovf are stable and in_ready=0. Any in_valid is not accepted and must be held by the producer.
- Simultaneous accept and emit in one cycle is legal: the pipe shifts, the new input enters stage 0 and the old result leaves.
- Results leave in acceptance order. There is no reordering or dropping except by reset.

## Test plan
- Reset/idle (WIDTH=32, STAGE_BITS=8): release rst_n with in_valid=0 for 10 cycles -> out_valid=0, out_sum=0, in_ready=1 throughout.
- Full carry ripple across stages: A=0xFFFFFFFF, B=0x00000001, ci=0, sub=0 -> 4 cycles later out_sum=0x00000000, out_co=1, out_ovf=0.
- Subtract and signed overflow: A=0x80000000, B=0x00000001, sub=1, ci=1 -> out_sum=0x7FFFFFFF, out_co=1, out_ovf=1. Then A=0x00000000, B=0x00000001, sub=1, ci=1 -> out_sum=0xFFFFFFFF, out_co=0, out_ovf=0.
- Back-to-back stream: 100 random transactions on consecutive cycles, out_ready=1 -> 100 results in order, each equal to the reference model, out_valid continuous after a 4-cycle fill.
- Backpressure: random out_ready (50%) plus random in_valid -> no loss or duplication. in_ready=0 exactly when out_valid && !out_ready. Outputs are stable during stalls.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> outputs go to 0 immediately and none of the 3 results ever appears. Repeat the random stream with STAGE_BITS=4 and STAGE_BITS=32 (NSTAGES=8 and NSTAGES=1) -> latencies 8 and 1.
